// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide unit beside the EX-stage ALU.
// Results land in HI/LO; busy stalls the pipeline while an operation runs.
module alu_muldiv_seq #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] CODE_MULTU = 6'h13,
  parameter logic [5:0] CODE_DIVU  = 6'h34
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ALUctrl,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // IDLE   | waiting for start with a long-latency code
  // MUL    | shift-add, one multiplier bit per cycle, LSB first
  // DIV    | restoring shift-subtract, one quotient bit per cycle, MSB first
  // DONE   | single cycle, HI/LO hold the new result
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_last;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_last     = (r_cnt == LAST_CNT);
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

  // The shifted partial remainder is one bit wider than the divisor, so
  // bit WIDTH of the difference is an exact borrow.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_nxt  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_fits};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ALUctrl == CODE_MULTU) begin
              r_mcand  <= {{WIDTH{1'b0}}, opA};
              r_mplier <= opB;
              r_prod   <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else if (ALUctrl == CODE_DIVU) begin
              if (opB == '0) begin
                r_hi    <= opA;
                r_lo    <= '1;
                r_state <= S_DONE;
              end else begin
                r_rem   <= '0;
                r_quo   <= opA;
                r_dvsr  <= opB;
                r_cnt   <= '0;
                r_state <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi    <= w_prod_nxt[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_nxt[WIDTH-1:0];
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi    <= w_rem_nxt;
            r_lo    <= w_quo_nxt;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: cycle-level arithmetic model plus directed vectors
// with hand-computed results.
module tb_alu_muldiv_seq;
  localparam int         W     = 32;
  localparam logic [5:0] MULTU = 6'h13;
  localparam logic [5:0] DIVU  = 6'h34;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    ALUctrl = 6'h00;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic cmp_en = 1'b0;

  alu_muldiv_seq #(.WIDTH(W), .CODE_MULTU(MULTU), .CODE_DIVU(DIVU)) dut (
    .clock(clock), .reset(reset), .start(start), .ALUctrl(ALUctrl),
    .opA(opA), .opB(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: cycles remaining until idle, and the result computed up front.
  int unsigned  m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;

  always @(posedge clock) begin
    int unsigned  left;
    logic [W-1:0] nh, nl, ph, pl;
    logic [63:0]  prod;
    left = m_left; nh = m_hi; nl = m_lo; ph = m_ph; pl = m_pl;
    if (reset) begin
      left = 0; nh = '0; nl = '0;
    end else if (left != 0) begin
      left = left - 1;
      if (left == 1) begin nh = ph; nl = pl; end
    end else if (start) begin
      if (ALUctrl == MULTU) begin
        prod = {32'b0, opA} * {32'b0, opB};
        ph = prod[63:32]; pl = prod[31:0]; left = W + 1;
      end else if (ALUctrl == DIVU) begin
        if (opB == 0) begin
          left = 1; nh = opA; nl = '1;
        end else begin
          ph = opA % opB; pl = opA / opB; left = W + 1;
        end
      end
    end
    m_left <= left; m_hi <= nh; m_lo <= nl; m_ph <= ph; m_pl <= pl;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp busy", {31'b0, busy}, {31'b0, m_left != 0});
      chk("cmp done", {31'b0, done}, {31'b0, m_left == 1});
      chk("cmp hi", hi, m_hi);
      chk("cmp lo", lo, m_lo);
      if (done === 1'b1) done_cnt++;
    end
  end

  // Called at a negedge; start is sampled at the next edge (edge 0).
  // Returns at the negedge of the first cycle after done.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output int bcnt);
    int k;
    start = 1'b1; ALUctrl = c; opA = a; opB = b;
    @(negedge clock);
    k = 1;
    start = 1'b0; opA = ~a; opB = b ^ 32'h5a5a_5a5a; ALUctrl = MULTU;
    dcyc = -1; bcnt = 0;
    while (dcyc < 0 && k <= 40) begin
      if (busy) bcnt++;
      if (done) dcyc = k;
      else begin @(negedge clock); k++; end
    end
    @(negedge clock);
  endtask

  int dcyc, bcnt, base, k;

  initial begin
    repeat (3) @(negedge clock);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    cmp_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, bcnt);
    chk("mulmax done_cycle", dcyc, 32'd33);
    chk("mulmax busy_cycles", bcnt, 32'd33);
    chk("mulmax busy_after", {31'b0, busy}, 32'd0);
    chk("mulmax hi", hi, 32'hFFFF_FFFE);
    chk("mulmax lo", lo, 32'h0000_0001);

    run_op(DIVU, 32'd100, 32'd7, dcyc, bcnt);
    chk("div100_7 done_cycle", dcyc, 32'd33);
    chk("div100_7 lo", lo, 32'd14);
    chk("div100_7 hi", hi, 32'd2);

    run_op(DIVU, 32'h8000_0000, 32'h8000_0001, dcyc, bcnt);
    chk("div_big lo", lo, 32'd0);
    chk("div_big hi", hi, 32'h8000_0000);

    run_op(DIVU, 32'h1234_5678, 32'd0, dcyc, bcnt);
    chk("div0 done_cycle", dcyc, 32'd1);
    chk("div0 busy_cycles", bcnt, 32'd1);
    chk("div0 busy_cycle2", {31'b0, busy}, 32'd0);
    chk("div0 hi", hi, 32'h1234_5678);
    chk("div0 lo", lo, 32'hFFFF_FFFF);

    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, dcyc, bcnt);
    chk("div_by1 lo", lo, 32'hFFFF_FFFF);
    chk("div_by1 hi", hi, 32'd0);

    run_op(DIVU, 32'd5, 32'd10, dcyc, bcnt);
    chk("div_small lo", lo, 32'd0);
    chk("div_small hi", hi, 32'd5);

    run_op(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, dcyc, bcnt);
    chk("mul_mix done_cycle", dcyc, 32'd33);

    // Starts during MUL and DONE are ignored; the one in cycle 34 is taken.
    base = done_cnt;
    start = 1'b1; ALUctrl = MULTU; opA = 32'd3; opB = 32'd5;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clock);
      if (c == 33) chk("ign done_at_33", {31'b0, done}, 32'd1);
      if (c == 34) begin
        chk("ign done_pulses", done_cnt - base, 32'd1);
        chk("ign busy_34", {31'b0, busy}, 32'd0);
        chk("ign hi", hi, 32'd0);
        chk("ign lo", lo, 32'd15);
      end
      if (c == 35) chk("ign fresh_busy", {31'b0, busy}, 32'd1);
      if (c == 5 || c == 33) begin
        start = 1'b1; ALUctrl = DIVU; opA = 32'd9; opB = 32'd3;
      end else if (c == 34) begin
        start = 1'b1; ALUctrl = DIVU; opA = 32'd45; opB = 32'd3;
      end else start = 1'b0;
    end
    k = 35;
    while (!done && k < 80) begin @(negedge clock); k++; end
    chk("fresh done_cycle", k, 32'd67);
    chk("fresh lo", lo, 32'd15);
    chk("fresh hi", hi, 32'd0);
    @(negedge clock);

    // Reset in cycle 10 aborts the multiply with no done pulse.
    base = done_cnt;
    start = 1'b1; ALUctrl = MULTU; opA = 32'h0001_0000; opB = 32'h0001_0000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 10) begin
        chk("rst held_lo", lo, 32'd15);
        reset = 1'b1;
      end
    end
    @(negedge clock);
    chk("rst busy_11", {31'b0, busy}, 32'd0);
    chk("rst hi_11", hi, 32'd0);
    chk("rst lo_11", lo, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("rst done_pulses", done_cnt - base, 32'd0);

    // Non-muldiv code is ignored.
    run_op(MULTU, 32'd7, 32'd6, dcyc, bcnt);
    chk("mul7_6 lo", lo, 32'd42);
    start = 1'b1; ALUctrl = 6'h02; opA = 32'd1; opB = 32'd2;
    @(negedge clock);
    start = 1'b0;
    chk("add busy", {31'b0, busy}, 32'd0);
    chk("add done", {31'b0, done}, 32'd0);
    @(negedge clock);
    chk("add busy2", {31'b0, busy}, 32'd0);
    chk("add hi", hi, 32'd0);
    chk("add lo", lo, 32'd42);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
